counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
// PURPOSE
//  Run/pause/step/direction/clear sequencer for the 4-bit LED counter datapath.
//  Produces the counter's one-cycle clock-enable strobe (ce) from an internal prescaler.
//  Also produces the direction (up) and synchronous-clear (clr) controls.
//  Inputs are synchronized button levels; this block edge-detects them internally.
//  Sits between the button synchronizers and the counter.
// PARAMETERS
//  CYCLES_PER_TICK  125_000_000  clk cycles between ce strobes while running (>=1; benches override small)
//  PS_W             $clog2(CYCLES_PER_TICK)+1  prescaler width (derived, do not override)
// PORTS
//  clk        in   1  system clock (125 MHz on board)
//  rst_n      in   1  synchronous active-low reset, sampled on posedge clk
//  btn_run    in   1  synchronized level; rising edge toggles run/pause
//  btn_step   in   1  synchronized level; rising edge issues one ce while paused
//  btn_dir    in   1  synchronized level; rising edge toggles count direction
//  btn_clear  in   1  synchronized level; rising edge clears counter and pauses
//  ce         out  1  one-cycle count-enable strobe to counter
//  up         out  1  count direction, 1=increment, 0=decrement
//  clr        out  1  one-cycle synchronous clear strobe to counter
//  running    out  1  1 while FSM is in RUN
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - FSM=PAUSED, prescaler=0.
//    - ce=0, clr=0, up=1, running=0.
//    - Edge-detect previous-value regs=1, so a button held through reset is not a press.
//  - All outputs registered.
//  - Press = input 1 while its previous-value reg is 0, sampled at cycle N.
//  - Effect of a press at cycle N is visible on outputs at cycle N+1.
//  - FSM states: PAUSED, RUN, STEP. Press priority: clear > run > step. dir is independent.
//  - clear (any state): clr=1 for exactly one cycle; FSM->PAUSED; prescaler->0; ce=0 that cycle.
//  - run in PAUSED: ->RUN; prescaler continues from its held value.
//  - run in RUN: ->PAUSED; prescaler holds its value.
//  - run in STEP: ->RUN after the step ce completes. The step strobe is never dropped.
//  - RUN counting, cycle by cycle:
//    - If prescaler==CYCLES_PER_TICK-1: prescaler->0 and ce=1 next cycle.
//    - Otherwise: prescaler increments.
//    - Strobes occur exactly every CYCLES_PER_TICK cycles.
//    - CYCLES_PER_TICK=1: ce is high every cycle in RUN.
//  - Pause landing on terminal count (run press while prescaler==CYCLES_PER_TICK-1): pause wins.
//    - No ce is issued; prescaler holds at terminal.
//    - On resume, ce fires on the first RUN cycle.
//  - step in PAUSED: ->STEP.
//    - ce=1 for exactly one cycle; prescaler unchanged; then ->PAUSED.
//    - step is ignored in RUN and STEP.
//  - dir press: up toggles at N+1 in any state, including simultaneously with any other press.
//    - A ce issued in the same cycle as the toggle uses the new up value.
//  - Simultaneous clear+run: clear wins; FSM ends PAUSED; the run press is discarded.
//  - Held buttons: only the rising edge acts; a held level causes no repeats.
//  - rst_n asserted mid-step or mid-tick: all state returns to reset values at that edge.
//    - No partial strobe is emitted.
//  - ce and clr are never both 1 in the same cycle.
// TESTING (bench uses CYCLES_PER_TICK=4)
//  1. Release reset, no presses for 20 cycles -> ce=0, clr=0, up=1, running=0 throughout.
//  2. run press, hold 20 cycles -> running=1; ce pulses exactly every 4 cycles (5 pulses);
//     the first pulse comes 4 cycles after running rises.
//  3. Pause after 2 RUN cycles, wait 10, resume -> no ce while paused;
//     the next ce comes 2 cycles after resume.
//  4. In PAUSED, 3 step presses spaced 5 cycles apart -> exactly 3 single-cycle ce pulses,
//     each 1 cycle after its press; step pressed in RUN -> no extra ce.
//  5. clear and run pressed in the same cycle while RUN -> clr=1 for one cycle,
//     running=0, no ce; the next run press restarts a full 4-cycle period.
//  6. dir press coincident with a tick ce -> up=0 in the same cycle as ce;
//     holding btn_dir 10 cycles toggles up exactly once.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Run/pause/step/direction/clear sequencer for the 4-bit LED counter.
//   Edge-detects synchronized button levels and produces registered
//   control strobes for the counter datapath.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   btn_run    rising edge toggles run/pause
//   btn_step   rising edge issues one ce while paused
//   btn_dir    rising edge toggles count direction
//   btn_clear  rising edge clears the counter and pauses
//   ce         one-cycle count-enable strobe
//   up         count direction (1 = increment)
//   clr        one-cycle synchronous clear strobe
//   running    high while in RUN
module counter_ctrl #(
  parameter int unsigned CYCLES_PER_TICK = 125_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_run,
  input  logic btn_step,
  input  logic btn_dir,
  input  logic btn_clear,
  output logic ce,
  output logic up,
  output logic clr,
  output logic running
);

  localparam int unsigned PS_W = $clog2(CYCLES_PER_TICK) + 1;
  localparam logic [PS_W-1:0] TERM = PS_W'(CYCLES_PER_TICK - 1);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t          state;
  logic [PS_W-1:0] ps;

  // Previous-value registers reset to 1 so a button held through reset
  // does not register as a press.
  logic run_q, step_q, dir_q, clear_q;

  logic p_run, p_step, p_dir, p_clear;

  always_comb begin
    p_run   = btn_run   & ~run_q;
    p_step  = btn_step  & ~step_q;
    p_dir   = btn_dir   & ~dir_q;
    p_clear = btn_clear & ~clear_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PAUSED;
      ps      <= '0;
      ce      <= 1'b0;
      clr     <= 1'b0;
      up      <= 1'b1;
      running <= 1'b0;
      run_q   <= 1'b1;
      step_q  <= 1'b1;
      dir_q   <= 1'b1;
      clear_q <= 1'b1;
    end else begin
      run_q   <= btn_run;
      step_q  <= btn_step;
      dir_q   <= btn_dir;
      clear_q <= btn_clear;

      if (p_dir) up <= ~up;

      ce  <= 1'b0;
      clr <= 1'b0;

      if (p_clear) begin
        clr     <= 1'b1;
        state   <= PAUSED;
        ps      <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          PAUSED: begin
            if (p_run) begin
              state   <= RUN;
              running <= 1'b1;
            end else if (p_step) begin
              state <= STEP;
              ce    <= 1'b1;
            end
          end
          RUN: begin
            // A pause press wins over the terminal count: prescaler holds,
            // so the pending tick fires on the first counting edge after resume.
            if (p_run) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (ps == TERM) begin
              ps <= '0;
              ce <= 1'b1;
            end else begin
              ps <= ps + PS_W'(1);
            end
          end
          STEP: begin
            // The step strobe was already issued on entry; a run press here
            // goes straight to RUN without losing it.
            if (p_run) begin
              state   <= RUN;
              running <= 1'b1;
            end else begin
              state <= PAUSED;
            end
          end
          default: begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_run, btn_step, btn_dir, btn_clear;
  logic ce, up, clr, running;

  int total = 0;
  int bad   = 0;

  counter_ctrl #(.CYCLES_PER_TICK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_dir   (btn_dir),
    .btn_clear (btn_clear),
    .ce        (ce),
    .up        (up),
    .clr       (clr),
    .running   (running)
  );

  always #5 clk = ~clk;

  // ce and clr must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (ce === 1'b1 && clr === 1'b1) begin
        bad++;
        $display("FAIL ce_clr_exclusive: ce=%b clr=%b required not both 1", ce, clr);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_run = 1'b0; btn_step = 1'b0; btn_dir = 1'b0; btn_clear = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    // Button held through reset must not count as a press.
    rst_n = 1'b0;
    btn_run = 1'b1; btn_step = 1'b0; btn_dir = 1'b0; btn_clear = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (running !== 1'b0) begin
        bad++;
        $display("FAIL held_through_reset: running=%b required 0", running);
      end
    end
    btn_run = 1'b0;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({ce, clr, up, running} !== 4'b0010) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: {ce,clr,up,running}=%b required 0010", i, {ce, clr, up, running});
      end
    end
  endtask

  task automatic test_run();
    int pulses;
    do_reset();
    btn_run = 1'b1;
    tick();
    total++;
    if (running !== 1'b1) begin
      bad++;
      $display("FAIL run_start: running=%b required 1", running);
    end
    pulses = 0;
    // Button stays held: no repeat toggles, ce every 4th cycle.
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ce === 1'b1) pulses++;
      total++;
      if (ce !== ((i % 4) == 0) || running !== 1'b1) begin
        bad++;
        $display("FAIL run_tick cyc%0d: ce=%b running=%b required ce=%b running=1", i, ce, running, (i % 4) == 0);
      end
    end
    btn_run = 1'b0;
    total++;
    if (pulses != 5) begin
      bad++;
      $display("FAIL run_pulse_count: got %0d required 5", pulses);
    end
  endtask

  task automatic test_pause();
    do_reset();
    btn_run = 1'b1; tick(); btn_run = 1'b0;   // running rises, ps=0
    tick(); tick();                            // ps=1, ps=2
    btn_run = 1'b1; tick(); btn_run = 1'b0;    // pause, ps holds at 2
    total++;
    if (running !== 1'b0 || ce !== 1'b0) begin
      bad++;
      $display("FAIL pause_enter: running=%b ce=%b required 0 0", running, ce);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (ce !== 1'b0 || running !== 1'b0) begin
        bad++;
        $display("FAIL paused_idle cyc%0d: ce=%b running=%b required 0 0", i, ce, running);
      end
    end
    btn_run = 1'b1; tick(); btn_run = 1'b0;    // resume
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (ce !== (i == 2)) begin
        bad++;
        $display("FAIL resume_tick cyc%0d: ce=%b required %b", i, ce, i == 2);
      end
    end
    // Now ps=1 after the cycle following the strobe; advance to terminal.
    tick(); tick();                            // ps=2, ps=3
    btn_run = 1'b1; tick(); btn_run = 1'b0;    // pause lands on terminal
    total++;
    if (ce !== 1'b0 || running !== 1'b0) begin
      bad++;
      $display("FAIL pause_terminal: ce=%b running=%b required 0 0", ce, running);
    end
    tick(); tick();
    btn_run = 1'b1; tick(); btn_run = 1'b0;    // resume, running rises
    tick();
    total++;
    if (ce !== 1'b1) begin
      bad++;
      $display("FAIL resume_terminal: ce=%b required 1", ce);
    end
  endtask

  task automatic test_step();
    int pulses;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      btn_step = 1'b1; tick(); btn_step = 1'b0;
      if (ce === 1'b1) pulses++;
      total++;
      if (ce !== 1'b1 || running !== 1'b0) begin
        bad++;
        $display("FAIL step_pulse k%0d: ce=%b running=%b required 1 0", k, ce, running);
      end
      for (int i = 0; i < 4; i++) begin
        tick();
        if (ce === 1'b1) pulses++;
        total++;
        if (ce !== 1'b0) begin
          bad++;
          $display("FAIL step_after k%0d cyc%0d: ce=%b required 0", k, i, ce);
        end
      end
    end
    total++;
    if (pulses != 3) begin
      bad++;
      $display("FAIL step_count: got %0d required 3", pulses);
    end
    // Step in RUN is ignored; ticks keep their 4-cycle schedule.
    btn_run = 1'b1; tick(); btn_run = 1'b0;   // E0 ps=0
    tick();                                    // E1 ps=1
    btn_step = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      btn_step = 1'b0;
      total++;
      if (ce !== (i == 4)) begin
        bad++;
        $display("FAIL step_in_run E%0d: ce=%b required %b", i, ce, i == 4);
      end
    end
  endtask

  task automatic test_clear_run();
    do_reset();
    btn_run = 1'b1; tick(); btn_run = 1'b0;   // E0
    tick(); tick();                            // ps=2
    btn_run = 1'b1; btn_clear = 1'b1;
    tick();
    btn_run = 1'b0; btn_clear = 1'b0;
    total++;
    if (clr !== 1'b1 || running !== 1'b0 || ce !== 1'b0) begin
      bad++;
      $display("FAIL clear_run: clr=%b running=%b ce=%b required 1 0 0", clr, running, ce);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (clr !== 1'b0 || running !== 1'b0 || ce !== 1'b0) begin
        bad++;
        $display("FAIL after_clear cyc%0d: clr=%b running=%b ce=%b required 0 0 0", i, clr, running, ce);
      end
    end
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (ce !== (i == 4) || running !== 1'b1) begin
        bad++;
        $display("FAIL restart cyc%0d: ce=%b running=%b required %b 1", i, ce, running, i == 4);
      end
    end
  endtask

  task automatic test_dir();
    do_reset();
    btn_run = 1'b1; tick(); btn_run = 1'b0;   // E0
    tick(); tick(); tick();                    // ps=3
    btn_dir = 1'b1;
    tick();                                    // E4: tick strobe with toggle
    total++;
    if (ce !== 1'b1 || up !== 1'b0) begin
      bad++;
      $display("FAIL dir_with_ce: ce=%b up=%b required 1 0", ce, up);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (up !== 1'b0) begin
        bad++;
        $display("FAIL dir_held cyc%0d: up=%b required 0", i, up);
      end
    end
    btn_dir = 1'b0;
    tick();
    btn_dir = 1'b1; tick(); btn_dir = 1'b0;
    total++;
    if (up !== 1'b1) begin
      bad++;
      $display("FAIL dir_second: up=%b required 1", up);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_dir = 1'b1; tick(); btn_dir = 1'b0;   // up=0
    btn_run = 1'b1; tick(); btn_run = 1'b0;   // E0
    tick(); tick(); tick();                    // ps=3, strobe due next edge
    rst_n = 1'b0;
    tick();
    total++;
    if ({ce, clr, up, running} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_mid_tick: {ce,clr,up,running}=%b required 0010", {ce, clr, up, running});
    end
    rst_n = 1'b1;
    tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    btn_run = 1'b0; btn_step = 1'b0; btn_dir = 1'b0; btn_clear = 1'b0;
    test_reset();
    test_run();
    test_pause();
    test_step();
    test_clear_run();
    test_dir();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
